// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the E-stage divide sequencer and its issuer.
interface div_seq_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  start_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     opa_i;
  logic [DATA_W-1:0]     opb_i;
  logic                  cancel_i;
  logic                  stall_o;
  logic                  busy_o;
  logic                  ready_o;
  logic [2*DATA_W-1:0]   result_o;

  modport master (
    output start_i, signed_i, opa_i, opb_i, cancel_i,
    input  stall_o, busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, opa_i, opb_i, cancel_i,
    output stall_o, busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Iterative radix-2 restoring DIV/DIVU sequencer; holds F/D/E via stall_o until {HI,LO} is ready.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |opa| < |opb|.
module div_seq_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  div_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   dvd;
  logic [DATA_W-1:0]   dvs;
  logic                neg_q;
  logic                neg_r;
  logic                ready;
  logic [2*DATA_W-1:0] result;

  logic [DATA_W-1:0]   a_abs;
  logic [DATA_W-1:0]   b_abs;
  logic [DATA_W:0]     trial;
  logic                ge;
  logic [DATA_W-1:0]   rem_nx;
  logic [DATA_W-1:0]   dvd_nx;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;

  // Operand magnitudes; abs(0x80000000) is 0x80000000 read as unsigned.
  always_comb begin
    a_abs = bus.opa_i;
    b_abs = bus.opb_i;
    if (bus.signed_i && bus.opa_i[DATA_W-1]) a_abs = DATA_W'(0) - bus.opa_i;
    if (bus.signed_i && bus.opb_i[DATA_W-1]) b_abs = DATA_W'(0) - bus.opb_i;
  end

  // One restoring step; the 33-bit trial keeps divisors above 2^31 exact.
  always_comb begin
    trial  = {rem, dvd[DATA_W-1]};
    ge     = (trial >= {1'b0, dvs});
    rem_nx = ge ? DATA_W'(trial - {1'b0, dvs}) : trial[DATA_W-1:0];
    dvd_nx = {dvd[DATA_W-2:0], ge};
    q_fix  = neg_q ? DATA_W'(0) - dvd_nx : dvd_nx;
    r_fix  = neg_r ? DATA_W'(0) - rem_nx : rem_nx;
  end

  // Sequencer state, datapath and registered result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.cancel_i) begin
            rem   <= '0;
            dvd   <= a_abs;
            dvs   <= b_abs;
            neg_q <= bus.signed_i & (bus.opa_i[DATA_W-1] ^ bus.opb_i[DATA_W-1]);
            neg_r <= bus.signed_i & bus.opa_i[DATA_W-1];
            cnt   <= '0;
            if (bus.opb_i == '0) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= {bus.opa_i, {DATA_W{1'b1}}};
`ifdef DIV_EARLY_OUT_EN
            end else if (a_abs < b_abs) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= {bus.opa_i, {DATA_W{1'b0}}};
`endif
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.cancel_i) begin
            state <= IDLE;
          end else begin
            rem <= rem_nx;
            dvd <= dvd_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W-1)) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= {r_fix, q_fix};
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o  = rst & ~bus.cancel_i &
                        (((state == IDLE) & bus.start_i) | (state == RUN));
  assign bus.busy_o   = (state != IDLE);
  assign bus.ready_o  = ready;
  assign bus.result_o = result;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, stall window, sign fix-up, divide-by-zero, cancel, reset.
module tb_div_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_seq_ctrl_if #(.DATA_W(32)) bus ();

  div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and follow it to ready_o, checking latency, stall window and result.
  task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    int stalls;
    bus.start_i  = 1'b1;
    bus.signed_i = sg;
    bus.opa_i    = a;
    bus.opb_i    = b;
    stalls = 0;
    #0;
    if (bus.stall_o) stalls++;
    step();
    bus.start_i = 1'b0;
    lat = 1;
    while (!bus.ready_o && lat < 40) begin
      if (bus.stall_o) stalls++;
      step();
      lat++;
    end
    checks++;
    if (bus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: ready_o never seen within %0d cycles", name, lat);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.result_o !== exp_res) begin
      errors++;
      $display("FAIL %s_result: got %h required %h", name, bus.result_o, exp_res);
    end
    checks++;
    if (stalls !== exp_lat) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d required %0d", name, stalls, exp_lat);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall_in_done: got %b required 0", name, bus.stall_o);
    end
    step();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: ready=%b busy=%b required 0 0", name, bus.ready_o, bus.busy_o);
    end
    checks++;
    if (bus.result_o !== exp_res) begin
      errors++;
      $display("FAIL %s_hold: got %h required %h", name, bus.result_o, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.opa_i = '0; bus.opb_i = '0; bus.cancel_i = 1'b0;
    step(); step();
    checks++;
    if ({bus.stall_o, bus.busy_o, bus.ready_o} !== 3'b000 || bus.result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset: stall=%b busy=%b ready=%b result=%h required all 0",
               bus.stall_o, bus.busy_o, bus.ready_o, bus.result_o);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_divu();
    run_div("divu_7_2", 1'b0, 32'd7, 32'd2, 33, {32'd1, 32'd3});
    run_div("divu_big_dvs", 1'b0, 32'hFFFFFFFF, 32'h80000001, 33, {32'h7FFFFFFE, 32'd1});
  endtask

  task automatic test_signed();
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, {32'd1, 32'hFFFFFFFD});
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {32'h00000000, 32'h80000000});
  endtask

  task automatic test_div_zero();
    run_div("divu_zero", 1'b0, 32'h1234, 32'd0, 1, {32'h1234, 32'hFFFFFFFF});
  endtask

  task automatic test_small_dividend();
`ifdef DIV_EARLY_OUT_EN
    run_div("divu_3_5", 1'b0, 32'd3, 32'd5, 1, {32'd3, 32'd0});
`else
    run_div("divu_3_5", 1'b0, 32'd3, 32'd5, 33, {32'd3, 32'd0});
`endif
  endtask

  task automatic test_start_cancel();
    logic [63:0] prev;
    prev = bus.result_o;
    bus.start_i = 1'b1; bus.cancel_i = 1'b1; bus.signed_i = 1'b0;
    bus.opa_i = 32'd100; bus.opb_i = 32'd7;
    #0;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL start_cancel_stall: got %b required 0", bus.stall_o);
    end
    step();
    bus.start_i = 1'b0; bus.cancel_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.result_o !== prev) begin
      errors++;
      $display("FAIL start_cancel_idle: busy=%b result=%h required 0 %h", bus.busy_o, bus.result_o, prev);
    end
  endtask

  task automatic test_cancel();
    logic [63:0] prev;
    logic        saw_ready;
    prev = bus.result_o;
    saw_ready = 1'b0;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opa_i = 32'd100; bus.opb_i = 32'd7;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.ready_o) saw_ready = 1'b1;
    end
    bus.cancel_i = 1'b1;
    #0;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL cancel_stall: got %b required 0", bus.stall_o);
    end
    step();
    bus.cancel_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || saw_ready) begin
      errors++;
      $display("FAIL cancel_state: busy=%b ready=%b early_ready=%b required 0 0 0",
               bus.busy_o, bus.ready_o, saw_ready);
    end
    for (int i = 0; i < 30; i++) begin
      if (bus.ready_o) saw_ready = 1'b1;
      step();
    end
    checks++;
    if (saw_ready || bus.result_o !== prev) begin
      errors++;
      $display("FAIL cancel_result: ready_seen=%b result=%h required 0 %h", saw_ready, bus.result_o, prev);
    end
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
  endtask

  task automatic test_mid_reset();
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opa_i = 32'd100; bus.opb_i = 32'd7;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    step();
    checks++;
    if ({bus.stall_o, bus.busy_o, bus.ready_o} !== 3'b000 || bus.result_o !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: stall=%b busy=%b ready=%b result=%h required all 0",
               bus.stall_o, bus.busy_o, bus.ready_o, bus.result_o);
    end
    rst = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_small_dividend();
    test_start_cancel();
    test_cancel();
    test_mid_reset();
    run_div("after_reset", 1'b1, 32'hFFFFFF9C, 32'd7, 33, {32'hFFFFFFFE, 32'hFFFFFFF2});
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
